// File: rtl/hv_capture_pkg.sv
// Shared types and default widths for the HD/VD pixel capture block.
package hv_capture_pkg;

  localparam int DEF_DW     = 12;
  localparam int DEF_HCNT_W = 16;
  localparam int DEF_VCNT_W = 13;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2
  } state_t;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [DEF_DW-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty come from
// pointers that carry one extra wrap bit.
module sync_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         do_wr_s;
  logic         do_rd_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_rd_s = rd_en & ~empty;
  // a write into a full FIFO is legal when the head leaves in the same cycle
  assign do_wr_s = wr_en & (~full | do_rd_s);
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // read/write pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // storage; cleared so the read port shows zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r <= '{default: {W{1'b0}}};
    end else if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/hv_pixel_capture.sv
// Captures HD/VD-framed pixels, tags SOF/EOL, buffers them on a
// valid/ready stream and measures line length and frame height.
module hv_pixel_capture
  import hv_capture_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = 16,
  parameter int HCNT_W     = DEF_HCNT_W,
  parameter int VCNT_W     = DEF_VCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hd_i,
  input  logic              vd_i,
  input  logic [DW-1:0]     pix_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic [HCNT_W-1:0] line_len_o,
  output logic [VCNT_W-1:0] frame_lines_o,
  output logic              meas_valid_o,
  output logic              overflow_o
);

  localparam logic [HCNT_W-1:0] HCNT_ONE = {{(HCNT_W-1){1'b0}}, 1'b1};
  localparam logic [VCNT_W-1:0] VCNT_ONE = {{(VCNT_W-1){1'b0}}, 1'b1};

  logic              hd_q_r, vd_q_r, hd_qq_r, vd_qq_r, s1_valid_r;
  logic [DW-1:0]     pix_q_r;
  state_t            state_r, state_nxt_s;
  logic              frame_start_s, frame_end_s;
  logic              vd_rise_s, vd_fall_s, capture_s;
  logic              hold_valid_r;
  logic [DW-1:0]     hold_data_r;
  logic              pending_sof_r;
  logic              wr_eol_s, eol_wr_s, rd_fire_s, wr_ok_s, drop_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [DW+1:0]     wr_entry_s, rd_entry_s;
  logic [HCNT_W-1:0] pix_cnt_r;
  logic [VCNT_W-1:0] line_cnt_r, line_cnt_inc_s;

  assign vd_rise_s = vd_q_r & ~vd_qq_r;
  assign vd_fall_s = ~vd_q_r & vd_qq_r;
  // the rising-edge cycle itself already carries an active pixel
  assign capture_s = vd_q_r & hd_q_r & ((state_r == FRAME) | frame_start_s);
  assign wr_eol_s  = ~(hd_q_r & vd_q_r);
  assign eol_wr_s  = hold_valid_r & wr_eol_s;
  assign rd_fire_s = ~fifo_empty_s & m_ready;
  assign wr_ok_s   = hold_valid_r & (~fifo_full_s | rd_fire_s);
  assign drop_s    = hold_valid_r & fifo_full_s & ~rd_fire_s;
  assign wr_entry_s     = {pending_sof_r, wr_eol_s, hold_data_r};
  assign line_cnt_inc_s = line_cnt_r + VCNT_ONE;

  // input sampling stage with one extra tap for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_q_r     <= 1'b0;
      vd_q_r     <= 1'b0;
      hd_qq_r    <= 1'b0;
      vd_qq_r    <= 1'b0;
      s1_valid_r <= 1'b0;
      pix_q_r    <= {DW{1'b0}};
    end else begin
      hd_q_r     <= hd_i;
      vd_q_r     <= vd_i;
      hd_qq_r    <= hd_q_r;
      vd_qq_r    <= vd_q_r;
      s1_valid_r <= 1'b1;
      pix_q_r    <= pix_i;
    end
  end

  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ARM;
    else        state_r <= state_nxt_s;
  end

  // next state; ARM ignores the reset value of vd_q and waits for a real low
  always_comb begin
    state_nxt_s   = state_r;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      ARM: begin
        if (s1_valid_r && !vd_q_r) state_nxt_s = IDLE;
        else                       state_nxt_s = ARM;
      end
      IDLE: begin
        if (vd_rise_s) begin
          state_nxt_s   = FRAME;
          frame_start_s = 1'b1;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      FRAME: begin
        if (vd_fall_s) begin
          state_nxt_s = IDLE;
          frame_end_s = 1'b1;
        end else begin
          state_nxt_s = FRAME;
        end
      end
      default: state_nxt_s = ARM;
    endcase
  end

  // one-pixel hold so EOL is known when the pixel is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_r  <= 1'b0;
      hold_data_r   <= {DW{1'b0}};
      pending_sof_r <= 1'b0;
    end else begin
      hold_valid_r <= capture_s;
      if (capture_s) hold_data_r <= pix_q_r;
      if (frame_start_s)  pending_sof_r <= 1'b1;
      else if (wr_ok_s)   pending_sof_r <= 1'b0;
    end
  end

  // line/frame measurement; a dropped EOL pixel still closes its line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_r     <= {HCNT_W{1'b0}};
      line_cnt_r    <= {VCNT_W{1'b0}};
      line_len_o    <= {HCNT_W{1'b0}};
      frame_lines_o <= {VCNT_W{1'b0}};
      meas_valid_o  <= 1'b0;
    end else begin
      if (eol_wr_s) begin
        line_len_o <= pix_cnt_r;
        pix_cnt_r  <= {HCNT_W{1'b0}};
      end else if (capture_s && !(&pix_cnt_r)) begin
        pix_cnt_r  <= pix_cnt_r + HCNT_ONE;
      end
      if (frame_start_s)  line_cnt_r <= {VCNT_W{1'b0}};
      else if (eol_wr_s)  line_cnt_r <= line_cnt_inc_s;
      if (frame_end_s) frame_lines_o <= eol_wr_s ? line_cnt_inc_s : line_cnt_r;
      meas_valid_o <= frame_end_s;
    end
  end

  // sticky drop flag, cleared on frame entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overflow_o <= 1'b0;
    else if (frame_start_s) overflow_o <= 1'b0;
    else if (drop_s)        overflow_o <= 1'b1;
  end

  sync_fifo #(
    .W     (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok_s),
    .wr_data (wr_entry_s),
    .rd_en   (m_ready),
    .rd_data (rd_entry_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign m_valid = ~fifo_empty_s;
  assign m_sof   = rd_entry_s[DW+1];
  assign m_eol   = rd_entry_s[DW];
  assign m_data  = rd_entry_s[DW-1:0];

endmodule

// File: tb/tb_hv_pixel_capture.sv
// Scoreboard bench for hv_pixel_capture: a sample-level reference model
// predicts every stream beat; a negedge monitor compares the FIFO head.
module tb_hv_pixel_capture;

  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int HW    = 16;
  localparam int VW    = 13;

  typedef struct packed {
    logic          sof;
    logic          eol;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          hd_i = 1'b0;
  logic          vd_i = 1'b0;
  logic [DW-1:0] pix_i = '0;
  logic          m_ready = 1'b0;
  logic          m_valid, m_sof, m_eol, meas_valid_o, overflow_o;
  logic [DW-1:0] m_data;
  logic [HW-1:0] line_len_o;
  logic [VW-1:0] frame_lines_o;

  hv_pixel_capture #(.DW(DW), .FIFO_DEPTH(DEPTH), .HCNT_W(HW), .VCNT_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .hd_i(hd_i), .vd_i(vd_i), .pix_i(pix_i),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .m_eol(m_eol), .line_len_o(line_len_o), .frame_lines_o(frame_lines_o),
    .meas_valid_o(meas_valid_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int beats = 0, seen_meas = 0, valid_seen = 0;
  int rdy_mode = 0;

  // reference model state (sample-level view of the spec)
  beat_t         exp_q[$];
  logic          last_valid = 1'b0, last_vd = 1'b0, last_hd = 1'b0;
  logic [DW-1:0] last_pix = '0;
  logic          prev_valid = 1'b0, prev_vd = 1'b0;
  logic          in_frame = 1'b0, held_valid = 1'b0, sof_pend = 1'b0;
  logic [DW-1:0] held_pix = '0;
  int            pix_cnt = 0, lines = 0, exp_line_len = 0, exp_frame_lines = 0;
  int            exp_meas = 0;
  logic          exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  // one input sample as the DUT sees it; held pixel resolved by this sample
  task automatic model_sample(input logic v, input logic h, input logic [DW-1:0] p);
    beat_t b;
    logic  eol;
    if (held_valid) begin
      eol = !(v && h);
      if (exp_q.size() >= DEPTH) begin
        exp_ovf = 1'b1;
      end else begin
        b.sof = sof_pend; b.eol = eol; b.data = held_pix;
        exp_q.push_back(b);
        sof_pend = 1'b0;
      end
      if (eol) begin
        exp_line_len = pix_cnt;
        pix_cnt = 0;
        lines++;
      end
      held_valid = 1'b0;
    end
    if (!in_frame && v && prev_valid && !prev_vd) begin
      in_frame = 1'b1; exp_ovf = 1'b0; lines = 0; sof_pend = 1'b1;
    end else if (in_frame && !v) begin
      in_frame = 1'b0; exp_frame_lines = lines; exp_meas++;
    end
    if (in_frame && v && h) begin
      held_valid = 1'b1; held_pix = p;
      if (pix_cnt < 65535) pix_cnt++;
    end
    prev_valid = 1'b1; prev_vd = v;
  endtask

  // model runs one sample behind so its pushes line up with FIFO writes
  initial begin : model
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        exp_q.delete();
        last_valid = 1'b0; prev_valid = 1'b0; in_frame = 1'b0;
        held_valid = 1'b0; sof_pend = 1'b0; pix_cnt = 0; lines = 0;
        exp_line_len = 0; exp_frame_lines = 0; exp_ovf = 1'b0;
      end else begin
        if (last_valid) model_sample(last_vd, last_hd, last_pix);
        last_valid = 1'b1; last_vd = vd_i; last_hd = hd_i; last_pix = pix_i;
      end
    end
  end

  // monitor: head of stream must match the model whenever it is presented
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (meas_valid_o) seen_meas++;
        if (m_valid) valid_seen++;
        chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        if (m_valid && exp_q.size() != 0) begin
          b = exp_q[0];
          chk("beat", 32'({m_sof, m_eol, m_data}), 32'(b));
          if (m_ready) begin
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
    end
  end

  // ready pattern generator
  initial begin : ready_drv
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        2:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic v, input logic h, input logic [DW-1:0] p);
    vd_i = v; hd_i = h; pix_i = p;
    @(posedge clk); #2;
  endtask

  task automatic run_line(input int act, input int blank);
    for (int i = 0; i < act; i++)   step(1'b1, 1'b1, rnd());
    for (int i = 0; i < blank; i++) step(1'b1, 1'b0, rnd());
  endtask

  task automatic run_frame(input int nl, input int act, input int blank, input int vblank);
    for (int l = 0; l < nl; l++) run_line(act, blank);
    for (int i = 0; i < vblank; i++) step(1'b0, 1'b0, rnd());
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    rdy_mode = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
    repeat (3) begin @(posedge clk); #2; end
  endtask

  initial begin : main
    int b0, m0, v0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_sof", 32'(m_sof), 32'd0);
    chk("rst_m_eol", 32'(m_eol), 32'd0);
    chk("rst_line_len", 32'(line_len_o), 32'd0);
    chk("rst_frame_lines", 32'(frame_lines_o), 32'd0);
    chk("rst_meas_valid", 32'(meas_valid_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // basic frame, 3 lines x 57 pixels
    rdy_mode = 0;
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, rnd());
    b0 = beats; m0 = seen_meas;
    run_frame(3, 57, 7, 10);
    wait_drain();
    chk("t1_beats", 32'(beats - b0), 32'd171);
    chk("t1_line_len", 32'(line_len_o), 32'd57);
    chk("t1_frame_lines", 32'(frame_lines_o), 32'd3);
    chk("t1_meas_pulses", 32'(seen_meas - m0), 32'd1);
    chk("t1_overflow", 32'(overflow_o), 32'd0);

    // latency of first pixel
    step(1'b1, 1'b1, 12'hABC);
    step(1'b1, 1'b1, rnd());
    chk("t2_valid_n1", 32'(m_valid), 32'd0);
    step(1'b1, 1'b1, rnd());
    chk("t2_valid_n2", 32'(m_valid), 32'd1);
    chk("t2_data_n2", 32'(m_data), 32'hABC);
    chk("t2_sof_n2", 32'(m_sof), 32'd1);
    run_line(7, 4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, rnd());
    wait_drain();
    chk("t2_line_len", 32'(line_len_o), 32'd10);
    chk("t2_frame_lines", 32'(frame_lines_o), 32'd1);

    // reset in the middle of a frame
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, rnd());
    run_line(20, 4);
    run_line(9, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rnd());
    rst_n = 1'b1;
    b0 = beats;
    run_line(6, 3);
    run_line(15, 3);
    run_line(15, 3);
    chk("t3_no_beats", 32'(beats - b0), 32'd0);
    chk("t3_no_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, rnd());
    b0 = beats;
    run_frame(1, 12, 3, 6);
    wait_drain();
    chk("t3_beats", 32'(beats - b0), 32'd12);
    chk("t3_line_len", 32'(line_len_o), 32'd12);

    // overflow with a stalled sink
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, rnd());
    b0 = beats;
    run_frame(1, 57, 7, 6);
    chk("t4_overflow_set", 32'(overflow_o), 32'd1);
    chk("t4_line_len", 32'(line_len_o), 32'd57);
    wait_drain();
    chk("t4_beats", 32'(beats - b0), 32'd16);
    chk("t4_overflow_sticky", 32'(overflow_o), 32'd1);
    b0 = beats;
    run_frame(1, 8, 2, 6);
    chk("t4_overflow_clr", 32'(overflow_o), 32'd0);
    wait_drain();
    chk("t4_beats2", 32'(beats - b0), 32'd8);

    // alternating ready
    rdy_mode = 2;
    b0 = beats;
    run_frame(1, 10, 4, 6);
    wait_drain();
    chk("t5_beats", 32'(beats - b0), 32'd10);
    chk("t5_line_len", 32'(line_len_o), 32'd10);

    // HD activity outside VD
    v0 = valid_seen;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rnd());
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, rnd());
    end
    chk("t6_no_valid", 32'(valid_seen - v0), 32'd0);
    chk("t6_line_len", 32'(line_len_o), 32'd10);

    // randomized frames with random backpressure
    for (int f = 0; f < 4; f++) begin
      int nl, act, blk;
      rdy_mode = 3;
      nl  = $urandom_range(1, 4);
      act = $urandom_range(1, 40);
      blk = $urandom_range(1, 6);
      run_frame(nl, act, blk, $urandom_range(2, 8));
      wait_drain();
      chk("rnd_line_len", 32'(line_len_o), 32'(exp_line_len));
      chk("rnd_frame_lines", 32'(frame_lines_o), 32'(exp_frame_lines));
      chk("rnd_overflow", 32'(overflow_o), 32'(exp_ovf));
    end
    chk("meas_total", 32'(seen_meas), 32'(exp_meas));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
